// File: rtl/lb_win_ctrl.sv
// Line-buffer window controller: pixel intake, window handshake, frame FSM.
// Optional LBC_STALL_CNT_EN adds a saturating window-stall counter output.
module lb_win_ctrl #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int KERNEL = 5
) (
  input  logic                     lbc_clk,
  input  logic                     lbc_rst,
  input  logic                     start_i,
  input  logic                     pix_valid_i,
  output logic                     pix_ready_o,
  output logic                     sr_en_o,
  output logic                     win_valid_o,
  input  logic                     win_ready_i,
  output logic [$clog2(IMG_W)-1:0] win_row_o,
  output logic [$clog2(IMG_W)-1:0] win_col_o,
  output logic                     busy_o,
  output logic                     frame_done_o
`ifdef LBC_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt_o
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] KM1C = CW'(KERNEL - 1);
  localparam logic [RW-1:0] KM1R = RW'(KERNEL - 1);
  localparam logic [CW-1:0] LASTC = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LASTR = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] in_col_q, in_col_d;
  logic [RW-1:0] in_row_q, in_row_d;
  logic          all_in_q, all_in_d;
  logic          win_valid_q, win_valid_d;
  logic [CW-1:0] win_row_q, win_row_d;
  logic [CW-1:0] win_col_q, win_col_d;

  logic accept;
  logic last_pix;
  logic gen;

  // Intake stalls while a window waits on the MAC.
  assign pix_ready_o = (state_q == S_RUN) && !all_in_q &&
                       !(win_valid_q && !win_ready_i);
  assign accept   = pix_valid_i && pix_ready_o;
  assign sr_en_o  = accept;
  assign last_pix = (in_col_q == LASTC) && (in_row_q == LASTR);
  assign gen      = accept && (in_row_q >= KM1R) && (in_col_q >= KM1C);

  assign win_valid_o  = win_valid_q;
  assign win_row_o    = win_row_q;
  assign win_col_o    = win_col_q;
  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = (state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    in_col_d    = in_col_q;
    in_row_d    = in_row_q;
    all_in_d    = all_in_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_RUN;
          in_col_d    = '0;
          in_row_d    = '0;
          all_in_d    = 1'b0;
          win_valid_d = 1'b0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (in_col_q == LASTC) begin
            in_col_d = '0;
            in_row_d = (in_row_q == LASTR) ? '0 : in_row_q + 1'b1;
          end else begin
            in_col_d = in_col_q + 1'b1;
          end
          if (last_pix) all_in_d = 1'b1;
        end
        win_valid_d = gen || (win_valid_q && !win_ready_i);
        if (gen) begin
          win_row_d = CW'(in_row_q - KM1R);
          win_col_d = in_col_q - KM1C;
        end
        if (all_in_d && !win_valid_d) state_d = S_DONE;
      end
      S_DONE: begin
        state_d     = S_IDLE;
        in_col_d    = '0;
        in_row_d    = '0;
        all_in_d    = 1'b0;
        win_valid_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge lbc_clk or posedge lbc_rst) begin
    if (lbc_rst) begin
      state_q     <= S_IDLE;
      in_col_q    <= '0;
      in_row_q    <= '0;
      all_in_q    <= 1'b0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_col_q    <= in_col_d;
      in_row_q    <= in_row_d;
      all_in_q    <= all_in_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

`ifdef LBC_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start_i) begin
      stall_d = '0;
    end else if (state_q == S_RUN && win_valid_q && !win_ready_i &&
                 stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge lbc_clk or posedge lbc_rst) begin
    if (lbc_rst) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule
